// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the round-robin memory write arbiter.
package mem_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int NREQ_D = 4;
  localparam int AW_D   = 3;
  localparam int DW_D   = 3;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or above rr_ptr, wrapping.
// Zero latency; no flow control of its own.
module rr_pick #(
  parameter  int NREQ = 4,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   rr_ptr,
  output logic [IW-1:0]   winner,
  output logic            any
);

  // Walk from the farthest offset down so the nearest set bit is written last.
  // NREQ is a power of two, so the IW-bit add wraps modulo NREQ for free.
  always_comb begin
    winner = '0;
    any    = |req;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[rr_ptr + IW'(k)]) begin
        winner = rr_ptr + IW'(k);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter granting NREQ write requesters onto one valid/ready memory port.
// 2-cycle minimum req-to-ack; valid and payload are held while ready is low.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NREQ = NREQ_D,
  parameter int AW   = AW_D,
  parameter int DW   = DW_D
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_value,
  output logic [NREQ-1:0]  ack,
  output logic             valid,
  output logic [AW-1:0]    data_in_addr,
  output logic [DW-1:0]    data_in_value,
  input  logic             ready,
  output logic             busy,
  output logic [7:0]       xfer_cnt
);

  localparam int IW = $clog2(NREQ);

  state_t          state;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   grant_idx;
  logic [IW-1:0]   winner;
  logic            any;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   value_q;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .winner (winner),
    .any    (any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_idx <= '0;
      xfer_cnt  <= '0;
      addr_q    <= '0;
      value_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any) begin
            grant_idx <= winner;
            addr_q    <= req_addr[int'(winner)*AW +: AW];
            value_q   <= req_value[int'(winner)*DW +: DW];
            state     <= BUSY;
          end
        end
        BUSY: begin
          // The winner drops to lowest priority once its write is accepted.
          if (ready) begin
            state    <= IDLE;
            rr_ptr   <= grant_idx + IW'(1);
            xfer_cnt <= xfer_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    ack = '0;
    if (state == BUSY && ready) begin
      ack[grant_idx] = 1'b1;
    end
  end

  assign valid         = (state == BUSY);
  assign busy          = (state == BUSY);
  assign data_in_addr  = addr_q;
  assign data_in_value = value_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters (power of two, 2..8).
REQ-002 Parameter AW, default 3, memory address width.
REQ-003 Parameter DW, default 3, memory data width.
REQ-004 clk  input  1  rising-edge clock; single clock domain.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 req  input  NREQ  per-requester write request; held high until the matching ack.
REQ-007 req_addr  input  NREQ*AW  packed per-requester write address; requester i occupies bits [i*AW +: AW].
REQ-008 req_value  input  NREQ*DW  packed per-requester write data; requester i occupies bits [i*DW +: DW].
REQ-009 ack  output  NREQ  one-hot, one-cycle completion strobe to the granted requester.
REQ-010 valid  output  1  write valid to the memory slave.
REQ-011 data_in_addr  output  AW  write address to the memory slave.
REQ-012 data_in_value  output  DW  write data to the memory slave.
REQ-013 ready  input  1  slave ready; a write transfers on a cycle with valid && ready.
REQ-014 busy  output  1  high while a transfer is outstanding.
REQ-015 xfer_cnt  output  8  count of completed transfers.

Function
REQ-016 The FSM SHALL have exactly two states: IDLE and BUSY.
REQ-017 In IDLE with any req bit high, the arbiter SHALL select the winner round-robin: first set bit searching upward from rr_ptr, modulo NREQ.
REQ-018 On that edge the arbiter SHALL latch grant_idx, req_addr[winner] and req_value[winner], and SHALL enter BUSY.
REQ-019 In IDLE with req == 0, the arbiter SHALL stay in IDLE.
REQ-020 In BUSY, valid SHALL be 1, data_in_addr/data_in_value SHALL be the latched values, and busy SHALL be 1.
REQ-021 In IDLE, valid and busy SHALL be 0; data_in_addr/data_in_value SHALL hold their last latched values.
REQ-022 Once asserted, valid SHALL stay high and addr/value SHALL stay stable until the cycle with ready == 1.
REQ-023 ack SHALL be combinational: ack[i] = (state == BUSY) && ready && (grant_idx == i).
REQ-024 On the handshake edge:
- state -> IDLE;
- rr_ptr -> (grant_idx + 1) mod NREQ;
- xfer_cnt increments, wrapping 255 -> 0.
REQ-025 Minimum transfer latency SHALL be 2 cycles from req high to ack (1 arbitration cycle, 1 BUSY cycle with ready already high); the arbiter SHALL add no further wait cycles.
REQ-026 If a granted requester drops req during BUSY, the latched transfer SHALL still complete and ack SHALL still pulse.
REQ-027 req changes on non-granted lines during BUSY SHALL NOT affect the outstanding transfer.
REQ-028 A requester SHALL be granted at most once per NREQ consecutive grants while others are pending (no starvation).
REQ-029 A requester that keeps req high after its ack SHALL be treated as a new request, with lowest priority after the rr_ptr update.

Reset
REQ-030 On rst_n low, regardless of state, the block SHALL immediately set:
- state = IDLE;
- valid = 0, busy = 0, ack = 0;
- rr_ptr = 0, grant_idx = 0, xfer_cnt = 0;
- latched addr and value = 0.
REQ-031 A transfer in flight at reset SHALL be abandoned with no ack and no counter update.
REQ-032 After reset release, the first grant SHALL go to the lowest-index requester that is asserting req.

Structure
REQ-033 Package mem_arb_pkg SHALL hold the state enum (IDLE, BUSY) and default constants NREQ_D = 4, AW_D = 3, DW_D = 3.
REQ-034 Round-robin selection SHALL be a combinational sub-module rr_pick:
- inputs: req vector, rr_ptr;
- outputs: winner index and any-request flag.
REQ-035 All state SHALL live in mem_arbiter in a single always_ff with async reset.

Verification
REQ-036 Single request: req = 0001, addr 5, value 3, ready already high -> valid for 1 cycle, ack = 0001 two cycles after req, xfer_cnt = 1.
REQ-037 Slave stall: req[2], ready low for 9 cycles -> valid and addr/value stable for all 10 BUSY cycles; ack = 0100 on the ready cycle only.
REQ-038 Contention: req = 1111 held continuously -> grant order 0,1,2,3,0; after 5 transfers rr_ptr = 1 and xfer_cnt = 5.
REQ-039 Mid-transfer reset: rst_n low during BUSY with ready low -> valid = 0 the same cycle, no ack, xfer_cnt = 0; after release with req = 1000 -> grant to 3.
REQ-040 Wrap: 256 back-to-back transfers -> xfer_cnt returns to 0, and the memory slave content at each written address equals the last value written to it.
